sm3_expnd_core: RTL
===================

# sm3_expnd_core

SM3 message-expansion core. It accepts each 512-bit padded block from the padding stage as 16 big-endian 32-bit words. It then produces the expanded sequence W_j and W'_j (j = 0..63) as an uninterrupted stream that drives the compression core's `expnd_inpt_*` port. Bus width is set by the shared configuration: 1 word per beat (`SM3_INPT_DW_32`) or 2 words per beat (`SM3_INPT_DW_64`).

## Interface
- No module parameters.
  - Width comes from `sm3_cfg.v`: `INPT_DW1` is 31 or 63.
  - N (words per beat) = 1 or 2.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `pad_inpt_data_i`  in  INPT_DW1+1  block words. In 64-bit mode, [63:32] is the earlier word and [31:0] the later word.
- `pad_inpt_vld_i`  in  1  input beat valid
- `pad_inpt_lst_i`  in  1  marks the final block of a message; sampled on the block's last load beat only
- `pad_inpt_rdy_o`  out  1  ready to accept a load beat
- `expnd_otpt_wj_o`  out  INPT_DW1+1  W_j. In 64-bit mode, {W_j, W_j+1}.
- `expnd_otpt_wjj_o`  out  INPT_DW1+1  W'_j = W_j ^ W_j+4. Same packing as `expnd_otpt_wj_o`.
- `expnd_otpt_lst_o`  out  1  last beat of the final block of the message
- `expnd_otpt_vld_o`  out  1  output beat valid

## Operation
- Storage is a 16 × 32-bit window `w[0..15]`, with `w[0]` the oldest word.
- State machine has two states: LOAD and EXPND.
- A 6-bit counter `cnt` steps by N in both states.
- **LOAD**
  - `pad_inpt_rdy_o` = 1.
  - Each accepted beat (vld & rdy) shifts the window down by N words and inserts the new words at the top, earlier word at the lower index.
  - The beat accepted with `cnt` == 16−N:
    - latches `pad_inpt_lst_i` into `blk_lst`;
    - clears `cnt`;
    - moves the state to EXPND.
- **EXPND**
  - `pad_inpt_rdy_o` = 0; input beats are ignored (upstream holds them).
  - Each cycle emits `expnd_otpt_vld_o` = 1, with W_j = `w[0]` and W'_j = `w[0] ^ w[4]`. In 64-bit mode the second word uses `w[1]` and `w[5]`.
  - The window shifts down by N and appends N new words.
  - New word: W_j+16 = P1(w0 ^ w7 ^ ROTL(w13,15)) ^ ROTL(w3,7) ^ w10, where P1(x) = x ^ ROTL(x,15) ^ ROTL(x,23).
  - Second word in 64-bit mode: W_j+17 uses w1, w8, w14, w4, w11. All of these are already in the window, so there is no chaining within the cycle.
  - `expnd_otpt_lst_o` = `blk_lst` on the beat with `cnt` == 64−N, and 0 on all other beats.
  - After that beat: `cnt` ← 0, state ← LOAD.
- Output vld is never deasserted within a block: 64/N consecutive beats. The compression core has no backpressure and depends on this.
- Block gap: after the final EXPND beat, LOAD needs at least 16/N cycles. This satisfies the compression core's minimum 3-cycle gap between blocks.
- Reset values:
  - state = LOAD, `cnt` = 0, window = 0, `blk_lst` = 0;
  - `pad_inpt_rdy_o` = 1, `expnd_otpt_vld_o` = 0, `expnd_otpt_lst_o` = 0;
  - `expnd_otpt_wj_o` = 0, `expnd_otpt_wjj_o` = 0.
- Reset mid-LOAD or mid-EXPND discards the partial block. The first beat after reset is word 0 of a new block.

## Timing
- All outputs come directly from flops, apart from one XOR level for W'_j.
- Final load beat accepted at edge T: the first output beat (j=0) is valid in cycle T+1, and `pad_inpt_rdy_o` drops in cycle T+1.
- Last output beat in cycle T+64/N; `pad_inpt_rdy_o` rises again in cycle T+64/N+1.
- Block throughput: 16/N + 64/N cycles (80 cycles in 32-bit mode, 40 in 64-bit mode).
- `pad_inpt_vld_i` may be low during LOAD: bubbles stall the load without corrupting the partial window.

## Structure
- `sm3_cfg.v` holds:
  - `INPT_DW1`, `SM3_INPT_DW_32` / `SM3_INPT_DW_64`;
  - the derived word-count constant (1/2);
  - the rotate amounts (15, 23, 7).
- Sub-module `sm3_expnd_ceil_comb`: combinational, takes five window words and returns one new W word. Instantiated N times.

## Test plan
- **"abc" block, 32-bit mode.** Words 61626380, 0×14, 00000018:
  - W0 = 61626380, W'0 = 61626380;
  - W16 = 9092e200, W18 = 000c0606;
  - W'12 = 9092e200, W'15 = 719c70f5;
  - exactly 64 consecutive vld beats.
  - Chained into the compression core with lst = 1: digest = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- **Same block in 64-bit mode:** 8 load beats, 32 output beats; first beat wj = {61626380, 00000000}.
- **Random vld bubbles during LOAD:** output stream identical to the no-bubble run; rdy = 0 throughout EXPND.
- **Two-block message, lst only on block 2:** `expnd_otpt_lst_o` pulses once, on beat 63 of block 2; block 1 beat 63 has lst = 0.
- **Reset asserted at output beat 20:** outputs return to reset values the same cycle; rdy = 1 after release; the next 16 words produce a correct W stream.
- **Input vld held high during EXPND:** no word accepted, window unaffected, and the next block loads correctly after rdy rises.

Source files
------------

// File: rtl/sm3_expnd_core_pkg.sv
// sm3_expnd_core_pkg: shared bus-width configuration, rotate amounts and FSM states for SM3 expansion
package sm3_expnd_core_pkg;
  localparam bit SM3_INPT_DW_32 = 1'b1;
  localparam bit SM3_INPT_DW_64 = !SM3_INPT_DW_32;
  localparam int N = SM3_INPT_DW_64 ? 2 : 1;
  localparam int INPT_DW1 = 32 * N - 1;
  localparam int ROT_P1A = 15;
  localparam int ROT_P1B = 23;
  localparam int ROT_W3 = 7;
  typedef enum logic {LOAD, EXPND} state_e;
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
endpackage

// File: rtl/sm3_expnd_ceil_comb.sv
// sm3_expnd_ceil_comb: one SM3 expansion step, W_j+16 from five window words
module sm3_expnd_ceil_comb
  import sm3_expnd_core_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w3,
  input  logic [31:0] w7,
  input  logic [31:0] w10,
  input  logic [31:0] w13,
  output logic [31:0] wn
);
  logic [31:0] x;
  // P1 permutation of the mixed term, then fold in the rotated w3 and w10
  always_comb begin
    x  = w0 ^ w7 ^ rotl(w13, ROT_P1A);
    wn = x ^ rotl(x, ROT_P1A) ^ rotl(x, ROT_P1B) ^ rotl(w3, ROT_W3) ^ w10;
  end
endmodule

// File: rtl/sm3_expnd_core.sv
// sm3_expnd_core: loads a 16-word block, then streams W_j / W'_j for j = 0..63 without gaps
module sm3_expnd_core
  import sm3_expnd_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPT_DW1:0] pad_inpt_data_i,
  input  logic              pad_inpt_vld_i,
  input  logic              pad_inpt_lst_i,
  output logic              pad_inpt_rdy_o,
  output logic [INPT_DW1:0] expnd_otpt_wj_o,
  output logic [INPT_DW1:0] expnd_otpt_wjj_o,
  output logic              expnd_otpt_lst_o,
  output logic              expnd_otpt_vld_o
);
  state_e      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic        blk_lst;
  logic [31:0] w [16];
  logic [31:0] nw [N];
  logic [31:0] in_w [N];
  logic        acc, shift, last_ld, last_ex;

  assign acc     = state == LOAD && pad_inpt_vld_i;
  assign shift   = acc || state == EXPND;
  assign last_ld = acc && cnt == 6'(16 - N);
  assign last_ex = state == EXPND && cnt == 6'(64 - N);

  assign pad_inpt_rdy_o   = state == LOAD;
  assign expnd_otpt_vld_o = state == EXPND;
  assign expnd_otpt_lst_o = last_ex && blk_lst;

  genvar k;
  for (k = 0; k < N; k++) begin : g_lane
    sm3_expnd_ceil_comb u_ceil (
      .w0 (w[k]),
      .w3 (w[k + 3]),
      .w7 (w[k + 7]),
      .w10(w[k + 10]),
      .w13(w[k + 13]),
      .wn (nw[k])
    );
    assign in_w[k] = state == EXPND ? nw[k] : pad_inpt_data_i[INPT_DW1 - 32 * k -: 32];
    assign expnd_otpt_wj_o[INPT_DW1 - 32 * k -: 32]  = w[k];
    assign expnd_otpt_wjj_o[INPT_DW1 - 32 * k -: 32] = w[k] ^ w[k + 4];
  end

  // next state and beat counter: the last load beat and the last output beat both wrap cnt
  always_comb begin
    state_n = last_ld ? EXPND : last_ex ? LOAD : state;
    cnt_n   = (last_ld || last_ex) ? 6'd0 : shift ? cnt + 6'(N) : cnt;
  end

  // control registers; the final-block flag is captured only on the block's last load beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      cnt     <= '0;
      blk_lst <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (last_ld) blk_lst <= pad_inpt_lst_i;
    end
  end

  // sliding window: oldest word drops out of w[0], new words (loaded or expanded) enter at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (shift) begin
      for (int i = 0; i < 16 - N; i++) w[i] <= w[i + N];
      for (int i = 0; i < N; i++) w[16 - N + i] <= in_w[i];
    end
  end
endmodule
